// File: rtl/emulador_dht22.sv
// emulador_dht22: DHT22 sensor-side responder for the single-wire bus.
// Ports: clk, reset (async, high); pino_dht_entrada (bus level);
//   umidade/temperatura/erro_checksum (frame data); pino_dht_oe (1 = pull
//   low); ocupado; quadro_enviado (1-clk pulse); estado_depuracao (state).
module emulador_dht22 #(
  parameter int CLKS_PER_US     = 100,
  parameter int T_INICIO_MIN_US = 800,
  parameter int T_ATRASO_US     = 30,
  parameter int T_RESP_US       = 80,
  parameter int T_BIT_BAIXO_US  = 50,
  parameter int T_BIT0_US       = 26,
  parameter int T_BIT1_US       = 70
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pino_dht_entrada,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
  input  logic        erro_checksum,
  output logic        pino_dht_oe,
  output logic        ocupado,
  output logic        quadro_enviado,
  output logic [3:0]  estado_depuracao
);

  localparam int MAXC = T_INICIO_MIN_US * CLKS_PER_US;
  localparam int W    = $clog2(MAXC + 1);

  // Terminal counts: a phase of N us ends when the counter reads N*C-1.
  localparam logic [W-1:0] L_INICIO =
    W'(T_INICIO_MIN_US * CLKS_PER_US - 1);
  localparam logic [W-1:0] L_ATRASO =
    W'(T_ATRASO_US * CLKS_PER_US - 1);
  localparam logic [W-1:0] L_RESP =
    W'(T_RESP_US * CLKS_PER_US - 1);
  localparam logic [W-1:0] L_BAIXO =
    W'(T_BIT_BAIXO_US * CLKS_PER_US - 1);
  localparam logic [W-1:0] L_BIT0 =
    W'(T_BIT0_US * CLKS_PER_US - 1);
  localparam logic [W-1:0] L_BIT1 =
    W'(T_BIT1_US * CLKS_PER_US - 1);

  typedef enum logic [3:0] {
    OCIOSO           = 4'd0,
    DET_INICIO       = 4'd1,
    ESPERA_LIBERACAO = 4'd2,
    ATRASO           = 4'd3,
    RESP_BAIXO       = 4'd4,
    RESP_ALTO        = 4'd5,
    BIT_BAIXO        = 4'd6,
    BIT_ALTO         = 4'd7,
    FIM_BAIXO        = 4'd8
  } estado_t;

  estado_t      r_estado;
  estado_t      w_prox;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_lim;
  logic         w_fim;
  logic         w_temporizado;
  logic [5:0]   r_idx;
  logic [5:0]   w_idx;
  logic [39:0]  r_quadro;
  logic         w_carrega;
  logic         r_sync1;
  logic         r_sync2;
  logic         w_linha;
  logic         r_oe;
  logic         r_ocupado;
  logic         r_enviado;
  logic [7:0]   w_soma;
  logic [7:0]   w_chk;

  assign w_linha = r_sync2;
  assign w_soma  = umidade[15:8] + umidade[7:0]
                 + temperatura[15:8] + temperatura[7:0];
  assign w_chk   = w_soma ^ {8{erro_checksum}};

  always_comb begin
    w_lim         = '0;
    w_temporizado = 1'b1;
    case (r_estado)
      DET_INICIO: w_lim = L_INICIO;
      ATRASO:     w_lim = L_ATRASO;
      RESP_BAIXO: w_lim = L_RESP;
      RESP_ALTO:  w_lim = L_RESP;
      BIT_BAIXO:  w_lim = L_BAIXO;
      FIM_BAIXO:  w_lim = L_BAIXO;
      BIT_ALTO:   w_lim = r_quadro[r_idx] ? L_BIT1 : L_BIT0;
      default:    w_temporizado = 1'b0;
    endcase
  end

  assign w_fim = (r_cnt == w_lim);

  always_comb begin
    w_prox    = r_estado;
    w_idx     = r_idx;
    w_carrega = 1'b0;
    case (r_estado)
      OCIOSO:
        if (!w_linha) w_prox = DET_INICIO;
      DET_INICIO:
        if (w_linha)    w_prox = OCIOSO;
        else if (w_fim) w_prox = ESPERA_LIBERACAO;
      ESPERA_LIBERACAO:
        if (w_linha) begin
          w_prox    = ATRASO;
          w_carrega = 1'b1;
        end
      ATRASO:
        if (w_fim) w_prox = RESP_BAIXO;
      RESP_BAIXO:
        if (w_fim) w_prox = RESP_ALTO;
      RESP_ALTO:
        if (w_fim) begin
          w_prox = BIT_BAIXO;
          w_idx  = 6'd39;
        end
      BIT_BAIXO:
        if (w_fim) w_prox = BIT_ALTO;
      BIT_ALTO:
        if (w_fim) begin
          if (r_idx == 6'd0) begin
            w_prox = FIM_BAIXO;
          end else begin
            w_prox = BIT_BAIXO;
            w_idx  = r_idx - 6'd1;
          end
        end
      FIM_BAIXO:
        if (w_fim) w_prox = OCIOSO;
      default:
        w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_estado  <= OCIOSO;
      r_cnt     <= '0;
      r_idx     <= 6'd39;
      r_quadro  <= '0;
      r_oe      <= 1'b0;
      r_ocupado <= 1'b0;
      r_enviado <= 1'b0;
    end else begin
      r_sync1  <= pino_dht_entrada;
      r_sync2  <= r_sync1;
      r_estado <= w_prox;
      r_idx    <= w_idx;
      if (w_prox != r_estado || !w_temporizado)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_carrega)
        r_quadro <= {umidade, temperatura, w_chk};
      // Outputs follow the next state so they line up with it.
      r_oe <= (w_prox == RESP_BAIXO) || (w_prox == BIT_BAIXO)
           || (w_prox == FIM_BAIXO);
      r_ocupado <= (w_prox != OCIOSO) && (w_prox != DET_INICIO);
      r_enviado <= (r_estado == FIM_BAIXO) && (w_prox == OCIOSO);
    end
  end

  assign pino_dht_oe      = r_oe;
  assign ocupado          = r_ocupado;
  assign quadro_enviado   = r_enviado;
  assign estado_depuracao = r_estado;

endmodule

// File: tb/tb_emulador_dht22.sv
// tb_emulador_dht22: drives host start pulses into emulador_dht22 and
// decodes the bus with a queue-based scoreboard.
module tb_emulador_dht22;

  localparam int C = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_low;
  logic        pin;
  logic [15:0] umid;
  logic [15:0] temp;
  logic        erro;
  logic        oe;
  logic        ocup;
  logic        env;
  logic [3:0]  est;

  int n_checks = 0;
  int n_fail   = 0;
  int ciclo    = 0;
  int t_rel    = 0;
  int frames_done = 0;
  int alvo     = 0;
  int mon_bit  = -1;
  int pulsos   = 0;
  bit expect_abort = 1'b0;
  logic [39:0] fila[$];

  assign pin = ~(host_low | oe);

  always #5 clk = ~clk;

  always @(posedge clk) ciclo <= ciclo + 1;

  always @(negedge clk) if (env === 1'b1) pulsos++;

  emulador_dht22 #(.CLKS_PER_US(C)) dut (
    .clk              (clk),
    .reset            (reset),
    .pino_dht_entrada (pin),
    .umidade          (umid),
    .temperatura      (temp),
    .erro_checksum    (erro),
    .pino_dht_oe      (oe),
    .ocupado          (ocup),
    .quadro_enviado   (env),
    .estado_depuracao (est)
  );

  task automatic chk(input string nome,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  function automatic logic [39:0] modelo(input logic [15:0] h,
                                         input logic [15:0] t,
                                         input logic e);
    int s;
    logic [7:0] b;
    s = (h >> 8) + (h & 255) + (t >> 8) + (t & 255);
    s = s % 256;
    if (e) s = 255 - s;
    b = s[7:0];
    return {h, t, b};
  endfunction

  task automatic corrida(input logic v, output int n, output bit ab);
    n = 0;
    while (oe === v && !reset && n < 200 * C) begin
      n++;
      @(negedge clk);
    end
    ab = reset;
  endtask

  task automatic decodifica();
    logic [39:0] esp;
    logic [39:0] got;
    int n;
    bit ab;
    got = '0;
    ab  = 1'b0;
    esp = (fila.size() > 0) ? fila[0] : '0;
    chk("fila_nao_vazia", 64'(fila.size() > 0), 1);
    // Two synchronizer stages plus the release decode cycle.
    chk("atraso", 64'(ciclo - t_rel), 64'(30 * C + 3));
    chk("ocupado_inicio", ocup, 1);
    corrida(1'b1, n, ab);
    if (!ab) chk("resp_baixo", 64'(n), 64'(80 * C));
    if (!ab) corrida(1'b0, n, ab);
    if (!ab) chk("resp_alto", 64'(n), 64'(80 * C));
    for (int i = 0; i < 40 && !ab; i++) begin
      mon_bit = i;
      corrida(1'b1, n, ab);
      if (ab) break;
      chk($sformatf("bit%0d_baixo", i), 64'(n), 64'(50 * C));
      corrida(1'b0, n, ab);
      if (ab) break;
      chk($sformatf("bit%0d_alto", i), 64'(n),
          esp[39-i] ? 64'(70 * C) : 64'(26 * C));
      got[39-i] = (n > 48 * C);
    end
    if (!ab) corrida(1'b1, n, ab);
    if (!ab) begin
      chk("fim_baixo", 64'(n), 64'(50 * C));
      chk("quadro_enviado", env, 1);
      chk("ocupado_fim", ocup, 0);
      chk("quadro", got, esp);
      @(negedge clk);
      chk("pulso_unico", env, 0);
    end
    if (fila.size() > 0) void'(fila.pop_front());
    if (ab) chk("abort_esperado", expect_abort, 1);
    else frames_done++;
    mon_bit = -1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (oe === 1'b1 && !reset) decodifica();
    end
  end

  task automatic espera_quadros(input int a);
    int k;
    k = 0;
    while (frames_done < a && k < 20000 * C) begin
      @(negedge clk);
      k++;
    end
    chk("quadros_completos", 64'(frames_done), 64'(a));
  endtask

  task automatic pulso_host(input int us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (us * C) @(negedge clk);
    host_low = 1'b0;
    t_rel = ciclo;
  endtask

  task automatic enviar(input logic [15:0] h, input logic [15:0] t,
                        input logic e, input logic [39:0] esp,
                        input int mudar);
    int k;
    umid = h;
    temp = t;
    erro = e;
    fila.push_back(esp);
    pulso_host(1000);
    alvo++;
    if (mudar == 1) begin
      k = 0;
      while (est !== 4'd4 && k < 2000 * C) begin
        @(negedge clk);
        k++;
      end
      chk("espera_resp_baixo", est, 4);
      umid = 16'h0300;
    end else if (mudar == 2) begin
      repeat (10) @(negedge clk);
      umid = 16'($urandom);
      temp = 16'($urandom);
      erro = ~erro;
    end
    espera_quadros(alvo);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [15:0] h;
    logic [15:0] t;
    logic        e;
    int viol;
    int k;
    reset    = 1'b1;
    host_low = 1'b0;
    umid     = '0;
    temp     = '0;
    erro     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_oe", oe, 0);
    chk("reset_ocupado", ocup, 0);
    chk("reset_enviado", env, 0);
    chk("reset_estado", est, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    enviar(16'h028C, 16'h00FA, 1'b0, 40'h028C00FA88, 0);
    enviar(16'h028C, 16'h00FA, 1'b1, 40'h028C00FA77, 0);

    viol = 0;
    @(negedge clk);
    host_low = 1'b1;
    repeat (500 * C) begin
      @(negedge clk);
      if (oe !== 1'b0 || ocup !== 1'b0) viol++;
    end
    host_low = 1'b0;
    repeat (1500 * C) begin
      @(negedge clk);
      if (oe !== 1'b0 || ocup !== 1'b0) viol++;
    end
    chk("glitch_sem_resposta", 64'(viol), 0);
    chk("glitch_estado", est, 0);

    enviar(16'hFFFF, 16'h8065, 1'b0, 40'hFFFF8065E3, 0);

    h = 16'($urandom);
    t = 16'($urandom);
    umid = h;
    temp = t;
    erro = 1'b0;
    fila.push_back(modelo(h, t, 1'b0));
    expect_abort = 1'b1;
    pulso_host(1000);
    k = 0;
    while (!(mon_bit == 19 && oe === 1'b1) && k < 20000 * C) begin
      @(negedge clk);
      k++;
    end
    chk("alcanca_bit19", oe, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_async_oe", oe, 0);
    chk("reset_async_estado", est, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_abort = 1'b0;
    repeat (5) @(negedge clk);

    enviar(16'h028C, 16'h00FA, 1'b0, 40'h028C00FA88, 0);
    enviar(16'h028C, 16'h00FA, 1'b0, 40'h028C00FA88, 1);

    repeat (2) begin
      h = 16'($urandom);
      t = 16'($urandom);
      e = 1'($urandom);
      enviar(h, t, e, modelo(h, t, e), 2);
    end

    chk("total_pulsos", 64'(pulsos), 7);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
